// File: rtl/led_ctrl.sv
// led_ctrl: CPU-configured LED driver with off/on/blink/PWM modes.
// Every config load restarts the selected mode from a clean count.
module led_ctrl #(
    parameter int TICK_DIV = 25000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] in,
    output logic [15:0] out,
    output logic        led
);
    typedef enum logic [2:0] {S_OFF, S_ON, S_BLINK_HI, S_BLINK_LO, S_PWM} state_t;
    state_t      state;
    logic [15:0] cfg;
    logic [15:0] presc;
    logic [7:0]  half;
    logic [7:0]  eff_period;
    logic [5:0]  pwm_cnt;
    logic [5:0]  duty;
    logic        tick;
    logic        blink;
    assign out        = cfg;
    assign duty       = cfg[7:2];
    assign eff_period = cfg[15:8] == 8'd0 ? 8'd1 : cfg[15:8];
    assign tick       = presc == 16'(TICK_DIV - 1);
    assign blink      = state == S_BLINK_HI || state == S_BLINK_LO;
    assign led        = state == S_ON || state == S_BLINK_HI || (state == S_PWM && pwm_cnt < duty);
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg     <= 16'h0000;
            state   <= S_OFF;
            presc   <= 16'd0;
            half    <= 8'd0;
            pwm_cnt <= 6'd0;
        end else if (load) begin
            cfg     <= in;
            state   <= in[1:0] == 2'b00 ? S_OFF :
                       in[1:0] == 2'b01 ? S_ON  :
                       in[1:0] == 2'b10 ? S_BLINK_HI : S_PWM;
            presc   <= 16'd0;
            half    <= 8'd0;
            pwm_cnt <= 6'd0;
        end else begin
            presc   <= blink ? (tick ? 16'd0 : presc + 16'd1) : 16'd0;
            pwm_cnt <= state == S_PWM ? pwm_cnt + 6'd1 : 6'd0;
            // half-period counter advances once per tick, only while blinking
            if (blink && tick) begin
                if (half == eff_period - 8'd1) begin
                    half  <= 8'd0;
                    state <= state == S_BLINK_HI ? S_BLINK_LO : S_BLINK_HI;
                end else begin
                    half <= half + 8'd1;
                end
            end else if (!blink) begin
                half <= 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_led_ctrl.sv
// tb_led_ctrl: scoreboard bench for led_ctrl with TICK_DIV=4.
module tb_led_ctrl;
    localparam int TD = 4;
    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] in;
    logic [15:0] out;
    logic        led;
    logic [16:0] sb[$];
    int          n_chk = 0;
    int          n_fail = 0;

    led_ctrl #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .load(load), .in(in), .out(out), .led(led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic l, input logic [15:0] d,
                        input logic exp_led, input logic [15:0] exp_out);
        logic [16:0] e;
        reset = r;
        load  = l;
        in    = d;
        sb.push_back({exp_led, exp_out});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, "_led"}, 32'(led), 32'(e[16]));
        check({tag, "_out"}, 32'(out), 32'(e[15:0]));
    endtask

    task automatic run_blink(input string tag, input logic [15:0] v, input int n);
        int p;
        p = v[15:8] == 8'd0 ? 1 : int'(v[15:8]);
        step(tag, 1'b0, 1'b1, v, 1'b1, v);
        for (int c = 2; c <= n; c++)
            step(tag, 1'b0, 1'b0, v, ((c - 1) / (TD * p)) % 2 == 0, v);
    endtask

    task automatic run_pwm(input string tag, input logic [15:0] v, input int n);
        int duty;
        duty = int'(v[7:2]);
        step(tag, 1'b0, 1'b1, v, duty > 0, v);
        for (int c = 2; c <= n; c++)
            step(tag, 1'b0, 1'b0, v, ((c - 1) % 64) < duty, v);
    endtask

    initial begin
        step("rst", 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        step("rst", 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        for (int i = 0; i < 100; i++) step("idle", 1'b0, 1'b0, 16'hffff, 1'b0, 16'h0000);
        step("on", 1'b0, 1'b1, 16'h0001, 1'b1, 16'h0001);
        for (int i = 0; i < 5; i++) step("on_hold", 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001);
        step("off", 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) step("off_hold", 1'b0, 1'b0, 16'h0001, 1'b0, 16'h0000);
        run_blink("blink2", 16'h0202, 56);
        run_blink("blink0", 16'h0002, 40);
        run_blink("blink1", 16'h0102, 24);
        run_pwm("pwm16", 16'h0043, 140);
        run_pwm("pwm0", 16'h0003, 70);
        run_pwm("pwm63", 16'h00ff, 140);
        run_pwm("pwm1", 16'h0007, 70);
        for (int i = 0; i < 20; i++) step("hold_load", 1'b0, 1'b1, 16'h0202, 1'b1, 16'h0202);
        for (int c = 2; c <= 20; c++)
            step("hold_rel", 1'b0, 1'b0, 16'h0000, ((c - 1) / (TD * 2)) % 2 == 0, 16'h0202);
        run_blink("mid_a", 16'h0202, 6);
        run_blink("mid_b", 16'h0302, 30);
        run_pwm("mid_pwm", 16'h0083, 10);
        run_blink("mid_c", 16'h0102, 12);
        run_blink("rst_mid", 16'h0202, 4);
        step("rst_pri", 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000);
        for (int i = 0; i < 20; i++) step("rst_idle", 1'b0, 1'b0, 16'h0001, 1'b0, 16'h0000);
        run_blink("restart", 16'h0202, 24);
        run_pwm("rst_pwm", 16'h0043, 8);
        step("rst_pwm_r", 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        for (int i = 0; i < 70; i++) step("rst_pwm_idle", 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/led_ctrl.md
LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000, meaning the number of clk cycles per blink tick (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port load  input  1  CPU write strobe for the config register.
REQ-005 SHALL have port in  input  16  CPU write data.
REQ-006 SHALL have port out  output  16  readback of the config register.
REQ-007 SHALL have port led  output  1  LED drive, active-high.
REQ-008 SHALL have one clock and a synchronous, active-high reset, with no other clock or asynchronous input.

Function
REQ-009 SHALL decode the config register as follows: cfg[1:0] is mode (00 OFF, 01 ON, 10 BLINK, 11 PWM); cfg[7:2] is the 6-bit PWM duty; cfg[15:8] is the blink half-period in ticks.
REQ-010 SHALL capture in into cfg on every rising edge where load=1 and reset=0; out SHALL equal cfg combinationally.
REQ-011 SHALL implement the FSM states S_OFF, S_ON, S_BLINK_HI, S_BLINK_LO and S_PWM.
REQ-012 SHALL, on a load edge, enter the state selected by in[1:0]: mode 10 enters S_BLINK_HI; the other modes enter the matching state.
REQ-013 SHALL, on a load edge, clear the tick prescaler, the half-period counter and the PWM counter to 0.
REQ-014 SHALL drive led combinationally from state: 1 in S_ON and S_BLINK_HI; 0 in S_OFF and S_BLINK_LO; (pwm_cnt < duty) in S_PWM.
REQ-015 SHALL make the new mode visible on led in the first cycle after the load edge (latency 1 cycle).
REQ-016 SHALL count the prescaler 0..TICK_DIV-1, wrapping to 0; tick SHALL be asserted when prescaler == TICK_DIV-1.
REQ-017 SHALL, in the blink states, increment the 8-bit half counter on each tick. When tick=1 and half == eff_period-1, it SHALL toggle between S_BLINK_HI and S_BLINK_LO and clear half to 0.
REQ-018 SHALL define eff_period = cfg[15:8], except that a value of 0 SHALL be treated as 1.
REQ-019 SHALL run the 6-bit PWM counter freely in S_PWM, incrementing each cycle and wrapping 63->0.
REQ-020 SHALL give a PWM duty of 0 led constantly 0, and a duty of 63 led high for 63 of every 64 cycles.
REQ-021 SHALL treat load held high for consecutive cycles as a restart on each cycle; in BLINK mode led therefore stays 1 and no toggle occurs.
REQ-022 SHALL hold all counters at 0 in S_OFF and S_ON.
REQ-023 SHALL NOT toggle from any stale count on a load that changes mode in the middle of a period; counters restart per REQ-013.

Reset
REQ-024 SHALL, on a reset edge, set cfg to 0x0000, set state to S_OFF and clear all counters; led=0 and out=0x0000 from the next cycle.
REQ-025 SHALL give reset priority over load on the same edge, so that load data is discarded.
REQ-026 SHALL have reset asserted in the middle of an operation (blink or PWM) abort it immediately with no residual toggle after deassertion.

Verification (TICK_DIV=4)
REQ-027 SHALL pass this scenario: assert reset for 2 cycles -> led=0, out=0x0000; idle for 100 cycles -> led stays 0.
REQ-028 SHALL pass this scenario: load with in=0x0001 -> next cycle led=1, out=0x0001; then load with in=0x0000 -> next cycle led=0.
REQ-029 SHALL pass this scenario: load with in=0x0202 -> led=1 for cycles 1-8, 0 for cycles 9-16, 1 for cycles 17-24, repeating with a period of 16.
REQ-030 SHALL pass this scenario: load with in=0x0002 (period 0) -> led toggles every 4 cycles (high 4 / low 4).
REQ-031 SHALL pass this scenario: load with in=0x0043 (PWM, duty 16) -> led=1 for 16 and then 0 for 48 of each 64 cycles; load with in=0x0003 -> led constantly 0.
REQ-032 SHALL pass this scenario: load 0x0202 and, at cycle 5, assert reset together with load in=0x0001 -> led=0, out=0x0000; then load with in=0x0202 after deassertion -> a full 8-cycle high phase restarts.
